// File: rtl/chef_pkg.sv
// Shared types and key constants for the chef motion scheduler.
// Optional feature macro: CHEF_TURN_BUFFER_EN (adds QUERY_BUF state).
package chef_pkg;

    typedef enum logic [2:0] {
        LEFT  = 3'd0,
        RIGHT = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        NONE  = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

`ifdef CHEF_TURN_BUFFER_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        QUERY     = 2'd1,
        QUERY_BUF = 2'd2,
        APPLY     = 2'd3
    } sched_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        APPLY = 2'd2
    } sched_state_t;
`endif

    function automatic dir_t key_to_dir(input logic [7:0] k);
        dir_t d;
        unique case (1'b1)
            (k == KEY_A): d = LEFT;
            (k == KEY_D): d = RIGHT;
            (k == KEY_W): d = UP;
            (k == KEY_S): d = DOWN;
            default:      d = NONE;
        endcase
        return d;
    endfunction

    function automatic logic is_vert(input dir_t d);
        return (d == UP) || (d == DOWN);
    endfunction

    function automatic dir_t opposite(input dir_t d);
        dir_t o;
        case (d)
            LEFT:    o = RIGHT;
            RIGHT:   o = LEFT;
            UP:      o = DOWN;
            DOWN:    o = UP;
            default: o = NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/chef_anim_counter.sv
// Walk-animation phase: counts committed moves, advances anim_frame
// every ANIM_DIV commits, and clears on an idle or rejected frame.
module chef_anim_counter
    import chef_pkg::*;
#(
    parameter int ANIM_DIV = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       step_commit,
    input  logic       idle_clear,
    output logic [1:0] anim_frame
);

    localparam int SW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(ANIM_DIV - 1);

    logic [SW-1:0] sub_cnt;

    // Sub-counter wraps into a phase advance; idle frames restart the walk
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sub_cnt    <= '0;
            anim_frame <= 2'd0;
        end else if (step_commit) begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt    <= '0;
                anim_frame <= anim_frame + 2'd1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end else if (idle_clear) begin
            sub_cnt    <= '0;
            anim_frame <= 2'd0;
        end
    end

endmodule

// File: rtl/chef_motion_sched.sv
// Per-frame chef motion scheduler: key decode, map query, commit/reject.
// Optional feature macro: CHEF_TURN_BUFFER_EN (buffered vertical turns).
module chef_motion_sched
    import chef_pkg::*;
#(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 192,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 216,
    parameter int X_START    = 96,
    parameter int Y_START    = 141,
    parameter int STEP       = 1,
    parameter int ANIM_DIV   = 4,
    parameter int BUF_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic       map_req,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    input  logic       map_ack,
    input  logic       map_floor,
    input  logic       map_ladder,
    output logic [9:0] ChefX,
    output logic [9:0] ChefY,
    output logic [1:0] chef_dir,
    output logic       chef_moving,
    output logic [1:0] anim_frame,
    output logic       busy
);

    localparam logic [9:0] STEP10 = 10'(STEP);
    localparam logic [9:0] XLO    = 10'(X_MIN + STEP);
    localparam logic [9:0] XHI    = 10'(X_MAX - STEP);
    localparam logic [9:0] YLO    = 10'(Y_MIN + STEP);
    localparam logic [9:0] YHI    = 10'(Y_MAX - STEP);

    sched_state_t state;
    dir_t         key_dir;
    dir_t         pend_dir;
    logic         legal;

    dir_t         kdir;
    dir_t         dsel;
    logic [9:0]   tx;
    logic [9:0]   ty;
    logic         t_ok;
    logic         use_buf;
    logic         step_commit;
    logic         idle_clear;

    assign kdir = key_to_dir(keycode);
    assign dsel = (state == IDLE) ? kdir : key_dir;

    // Target tile and bounds check for the live (or latched) key
    always_comb begin
        tx   = ChefX;
        ty   = ChefY;
        t_ok = 1'b0;
        case (dsel)
            LEFT: begin
                tx   = ChefX - STEP10;
                t_ok = (ChefX >= XLO);
            end
            RIGHT: begin
                tx   = ChefX + STEP10;
                t_ok = (ChefX <= XHI);
            end
            UP: begin
                ty   = ChefY - STEP10;
                t_ok = (ChefY >= YLO);
            end
            DOWN: begin
                ty   = ChefY + STEP10;
                t_ok = (ChefY <= YHI);
            end
            default: ;
        endcase
    end

`ifdef CHEF_TURN_BUFFER_EN
    localparam int BW = $clog2(BUF_FRAMES + 1);

    dir_t          buf_dir;
    logic [BW-1:0] buf_life;
    logic [9:0]    buf_ty;
    logic          buf_ok;

    // Buffered vertical target, skipped when the opposite key is held
    always_comb begin
        buf_ty = ChefY + STEP10;
        buf_ok = (ChefY <= YHI);
        if (buf_dir == UP) begin
            buf_ty = ChefY - STEP10;
            buf_ok = (ChefY >= YLO);
        end
        use_buf = (buf_life != '0) && buf_ok &&
                  (kdir != opposite(buf_dir));
    end
`else
    assign use_buf = 1'b0;
`endif

    assign step_commit = (state == APPLY) && legal;
    assign idle_clear  = (state == APPLY) && !legal;

    // Scheduler FSM with registered outputs and position state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            key_dir     <= NONE;
            pend_dir    <= NONE;
            legal       <= 1'b0;
            map_req     <= 1'b0;
            map_x       <= 10'd0;
            map_y       <= 10'd0;
            ChefX       <= 10'(X_START);
            ChefY       <= 10'(Y_START);
            chef_dir    <= 2'd1;
            chef_moving <= 1'b0;
            busy        <= 1'b0;
`ifdef CHEF_TURN_BUFFER_EN
            buf_dir     <= UP;
            buf_life    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        busy    <= 1'b1;
                        key_dir <= kdir;
`ifdef CHEF_TURN_BUFFER_EN
                        if (buf_life != '0)
                            buf_life <= buf_life - 1'b1;
`endif
                        if (use_buf) begin
`ifdef CHEF_TURN_BUFFER_EN
                            state   <= QUERY_BUF;
                            map_req <= 1'b1;
                            map_x   <= ChefX;
                            map_y   <= buf_ty;
`endif
                        end else if (kdir != NONE && t_ok) begin
                            state    <= QUERY;
                            map_req  <= 1'b1;
                            map_x    <= tx;
                            map_y    <= ty;
                            pend_dir <= kdir;
                        end else begin
                            state    <= APPLY;
                            pend_dir <= NONE;
                            legal    <= 1'b0;
                        end
                    end
                end
                QUERY: begin
                    if (!map_req) begin
                        map_req <= 1'b1;
                    end else if (map_ack) begin
                        map_req <= 1'b0;
                        legal   <= is_vert(pend_dir) ?
                                   map_ladder : map_floor;
                        state   <= APPLY;
                    end
                end
`ifdef CHEF_TURN_BUFFER_EN
                QUERY_BUF: begin
                    if (map_ack) begin
                        map_req <= 1'b0;
                        if (map_ladder) begin
                            pend_dir <= buf_dir;
                            legal    <= 1'b1;
                            buf_life <= '0;
                            state    <= APPLY;
                        end else if (key_dir != NONE && t_ok) begin
                            pend_dir <= key_dir;
                            map_x    <= tx;
                            map_y    <= ty;
                            state    <= QUERY;
                        end else begin
                            pend_dir <= NONE;
                            legal    <= 1'b0;
                            state    <= APPLY;
                        end
                    end
                end
`endif
                APPLY: begin
                    if (legal) begin
                        ChefX       <= map_x;
                        ChefY       <= map_y;
                        chef_dir    <= pend_dir[1:0];
                        chef_moving <= 1'b1;
                    end else begin
                        chef_moving <= 1'b0;
`ifdef CHEF_TURN_BUFFER_EN
                        if (is_vert(pend_dir)) begin
                            buf_dir  <= pend_dir;
                            buf_life <= BW'(BUF_FRAMES);
                        end
`endif
                    end
                    legal <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    map_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    chef_anim_counter #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .step_commit (step_commit),
        .idle_clear  (idle_clear),
        .anim_frame  (anim_frame)
    );

endmodule

// File: tb/tb_chef_motion_sched.sv
// Directed bench for chef_motion_sched: vector table plus
// hand-written latency, boundary, reset and turn-buffer sequences.
module tb_chef_motion_sched;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       map_req;
    logic [9:0] map_x;
    logic [9:0] map_y;
    logic       map_ack = 1'b0;
    logic       map_floor = 1'b0;
    logic       map_ladder = 1'b0;
    logic [9:0] ChefX;
    logic [9:0] ChefY;
    logic [1:0] chef_dir;
    logic       chef_moving;
    logic [1:0] anim_frame;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    chef_motion_sched dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .keycode     (keycode),
        .map_req     (map_req),
        .map_x       (map_x),
        .map_y       (map_y),
        .map_ack     (map_ack),
        .map_floor   (map_floor),
        .map_ladder  (map_ladder),
        .ChefX       (ChefX),
        .ChefY       (ChefY),
        .chef_dir    (chef_dir),
        .chef_moving (chef_moving),
        .anim_frame  (anim_frame),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] key;
        logic       fl;
        logic       ld;
        logic       q;
        int         qx;
        int         qy;
        int         x;
        int         y;
        int         dir;
        int         mov;
        int         anim;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One frame: tick, answer every map request, wait for IDLE
    task automatic do_frame(input logic [7:0] k, input logic fl,
                            input logic ld, output logic q,
                            output logic [9:0] qx, output logic [9:0] qy,
                            output logic to);
        q  = 1'b0;
        qx = '0;
        qy = '0;
        to = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b1;
        keycode    = k;
        map_floor  = fl;
        map_ladder = ld;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (map_ack) begin
                map_ack = 1'b0;
            end else if (map_req) begin
                map_ack = 1'b1;
                if (!q) begin
                    qx = map_x;
                    qy = map_y;
                end
                q = 1'b1;
            end
            if (!busy && !map_ack) begin
                to = 1'b0;
                break;
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic frame_chk(input string nm, input logic [7:0] k,
                             input logic fl, input logic ld);
        logic q, to;
        logic [9:0] qx, qy;
        do_frame(k, fl, ld, q, qx, qy, to);
        chk({nm, "_timeout"}, to, 0);
    endtask

    initial begin
        logic q, to;
        logic [9:0] qx, qy;
        int x0;

        tbl[0] = '{8'h07, 1'b1, 1'b0, 1'b1, 97, 141, 97, 141, 1, 1, 0};
        tbl[1] = '{8'h1A, 1'b0, 1'b0, 1'b1, 97, 140, 97, 141, 1, 0, 0};
        tbl[2] = '{8'h1A, 1'b0, 1'b1, 1'b1, 97, 140, 97, 140, 2, 1, 0};
        tbl[3] = '{8'h16, 1'b0, 1'b1, 1'b1, 97, 141, 97, 141, 3, 1, 0};
        tbl[4] = '{8'h04, 1'b1, 1'b0, 1'b1, 96, 141, 96, 141, 0, 1, 0};
        tbl[5] = '{8'h04, 1'b1, 1'b0, 1'b1, 95, 141, 95, 141, 0, 1, 1};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 95, 141, 0, 0, 0};
        tbl[7] = '{8'h04, 1'b0, 1'b1, 1'b1, 94, 141, 95, 141, 0, 0, 0};
        tbl[8] = '{8'h05, 1'b1, 1'b1, 1'b0, 0, 0, 95, 141, 0, 0, 0};

        #12;
        chk("rst_x", ChefX, 96);
        chk("rst_y", ChefY, 141);
        chk("rst_dir", chef_dir, 1);
        chk("rst_mov", chef_moving, 0);
        chk("rst_anim", anim_frame, 0);
        chk("rst_req", map_req, 0);
        chk("rst_busy", busy, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_frame(tbl[i].key, tbl[i].fl, tbl[i].ld, q, qx, qy, to);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_query", i), q, tbl[i].q);
            if (tbl[i].q) begin
                chk($sformatf("v%0d_qx", i), qx, tbl[i].qx);
                chk($sformatf("v%0d_qy", i), qy, tbl[i].qy);
            end
            chk($sformatf("v%0d_x", i), ChefX, tbl[i].x);
            chk($sformatf("v%0d_y", i), ChefY, tbl[i].y);
            chk($sformatf("v%0d_dir", i), chef_dir, tbl[i].dir);
            chk($sformatf("v%0d_mov", i), chef_moving, tbl[i].mov);
            chk($sformatf("v%0d_anim", i), anim_frame, tbl[i].anim);
        end

        // Eight right moves: two phase advances, then an idle clear
        for (int i = 1; i <= 8; i++) begin
            frame_chk("walk", 8'h07, 1'b1, 1'b0);
            if (i == 4) chk("walk4_anim", anim_frame, 1);
        end
        chk("walk8_x", ChefX, 103);
        chk("walk8_anim", anim_frame, 2);
        frame_chk("walk_idle", 8'h00, 1'b0, 1'b0);
        chk("walk_idle_anim", anim_frame, 0);
        chk("walk_idle_mov", chef_moving, 0);

        // Walk to the left edge, then push against it
        for (int i = 0; i < 103; i++)
            frame_chk("run_left", 8'h04, 1'b1, 1'b0);
        chk("edge_x", ChefX, 0);
        do_frame(8'h04, 1'b1, 1'b0, q, qx, qy, to);
        chk("edge_timeout", to, 0);
        chk("edge_noquery", q, 0);
        chk("edge_x_hold", ChefX, 0);
        chk("edge_mov", chef_moving, 0);
        chk("edge_dir", chef_dir, 0);

        // Minimum latency with map_ack held high from before the tick
        @(posedge Clk); #1;
        map_ack    = 1'b1;
        map_floor  = 1'b1;
        map_ladder = 1'b0;
        @(posedge Clk); #1;
        chk("held_ack_idle_req", map_req, 0);
        frame_tick = 1'b1;
        keycode    = 8'h07;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        chk("lat_c1_req", map_req, 1);
        chk("lat_c1_busy", busy, 1);
        chk("lat_c1_mx", map_x, 1);
        @(posedge Clk); #1;
        map_ack = 1'b0;
        chk("lat_c2_req", map_req, 0);
        chk("lat_c2_x", ChefX, 0);
        @(posedge Clk); #1;
        chk("lat_c3_x", ChefX, 1);
        chk("lat_c3_mov", chef_moving, 1);
        chk("lat_c3_dir", chef_dir, 1);
        chk("lat_c3_busy", busy, 0);

        // Asynchronous reset while a query is outstanding
        @(posedge Clk); #1;
        frame_tick = 1'b1;
        keycode    = 8'h07;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        chk("mq_req", map_req, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mq_rst_req", map_req, 0);
        chk("mq_rst_busy", busy, 0);
        chk("mq_rst_x", ChefX, 96);
        chk("mq_rst_y", ChefY, 141);
        chk("mq_rst_dir", chef_dir, 1);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        x0 = ChefX;

`ifdef CHEF_TURN_BUFFER_EN
        // Rejected W is retried ahead of later D ticks
        frame_chk("tb_w", 8'h1A, 1'b0, 1'b0);
        chk("tb_w_y", ChefY, 141);
        chk("tb_w_mov", chef_moving, 0);
        do_frame(8'h07, 1'b1, 1'b0, q, qx, qy, to);
        chk("tb_d1_timeout", to, 0);
        chk("tb_d1_qy", qy, 140);
        chk("tb_d1_x", ChefX, x0 + 1);
        frame_chk("tb_d2", 8'h07, 1'b1, 1'b0);
        chk("tb_d2_x", ChefX, x0 + 2);
        frame_chk("tb_d3", 8'h07, 1'b1, 1'b1);
        chk("tb_d3_x", ChefX, x0 + 2);
        chk("tb_d3_y", ChefY, 140);
        chk("tb_d3_dir", chef_dir, 2);
        chk("tb_d3_mov", chef_moving, 1);
`else
        frame_chk("post_rst", 8'h16, 1'b0, 1'b1);
        chk("post_rst_x", ChefX, x0);
        chk("post_rst_y", ChefY, 142);
        chk("post_rst_dir", chef_dir, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
